// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the key/switch reader
package kbd_pkg;
  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} db_state_e;
  localparam logic [1:0] REG_SW    = 2'd0;
  localparam logic [1:0] REG_KEY   = 2'd1;
  localparam logic [1:0] REG_FLAGS = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;
  localparam int CNT_W = 16;
endpackage

// File: rtl/key_switch_reader_debounce_bit.sv
// debounce_bit: 2-flop synchronizer plus counting debouncer for one input bit
module debounce_bit
  import kbd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q, sync_d;
  db_state_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic b, done;
  // inverted inputs reset to their idle level so a released key never looks pressed
  assign b = sync_q[1] ^ INVERT;
  assign cnt_inc = cnt_q + 1'b1;
  assign done = cnt_inc == LAST;
  assign level = st_q == STABLE_HI || st_q == CHK_LO;
  always_comb begin
    sync_d = {sync_q[0], raw};
    st_d = st_q;
    cnt_d = cnt_q;
    rise = 1'b0;
    case (st_q)
      STABLE_LO: if (b) begin st_d = CHK_HI; cnt_d = '0; end
      CHK_HI: if (!b) st_d = STABLE_LO;
              else if (done) begin st_d = STABLE_HI; rise = 1'b1; end
              else cnt_d = cnt_inc;
      STABLE_HI: if (!b) begin st_d = CHK_LO; cnt_d = '0; end
      CHK_LO: if (b) st_d = STABLE_HI;
              else if (done) st_d = STABLE_LO;
              else cnt_d = cnt_inc;
      default: st_d = STABLE_LO;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {2{INVERT}};
      st_q <= STABLE_LO;
      cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/key_switch_reader.sv
// key_switch_reader: debounced KEY/SW inputs, sticky press flags and press counter behind a read port
module key_switch_reader
  import kbd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int N_KEYS          = 4,
  parameter int N_SW            = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n_in,
  input  logic [N_SW-1:0]   sw_in,
  input  logic              rd_req,
  input  logic [1:0]        rd_addr,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic [N_KEYS-1:0] key_level,
  output logic              irq
);
  localparam int NB = N_KEYS + N_SW;
  logic [NB-1:0] raw, lvl, rise_all;
  logic [N_KEYS-1:0] key_rise, flags_q, flags_d;
  logic [N_SW-1:0] sw_lvl;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d, inc;
  logic rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d, mux;
  assign raw = {sw_in, key_n_in};
  for (genvar i = 0; i < NB; i++) begin : g_db
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(i < N_KEYS)) u_db (
      .clk(clk), .reset_n(reset_n), .raw(raw[i]), .level(lvl[i]), .rise(rise_all[i])
    );
  end
  // switch rise pulses are not press events
  assign key_rise = N_KEYS'(rise_all);
  assign key_level = lvl[N_KEYS-1:0];
  assign sw_lvl = lvl[NB-1:N_KEYS];
  assign irq = |flags_q;
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  always_comb begin
    inc = '0;
    for (int k = 0; k < N_KEYS; k++) inc = inc + CNT_W'(key_rise[k]);
    mux = rd_addr == REG_SW    ? 32'(sw_lvl) :
          rd_addr == REG_KEY   ? 32'(key_level) :
          rd_addr == REG_FLAGS ? 32'(flags_q) : 32'(press_cnt_q);
    // clearing exactly the returned snapshot leaves only same-cycle presses set
    flags_d = (rd_req && rd_addr == REG_FLAGS) ? key_rise : flags_q | key_rise;
    press_cnt_d = press_cnt_q + inc;
    rd_valid_d = rd_req;
    rd_data_d = rd_req ? mux : rd_data_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
      press_cnt_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      flags_q <= flags_d;
      press_cnt_q <= press_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule
